pc_sequencer: RTL and testbench

- Owns the program counter of the single-cycle MIPS core and generates the fetch address for the instruction ROM.
- Each cycle, selects the next PC from sequential, branch, jump, jr, interrupt and exception sources.
- Maintains the kernel/user mode bit (PC[31]) and the pending-interrupt latch.
- Supplies the return address to be written into $26 (Xp) when a trap is taken.

---
 rtl/pc_sequencer.sv | 131 +++++++++++++
 tb/tb_pc_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-cycle MIPS core: next-PC selection, traps, kernel bit.
// Optional cause/EPC capture registers are built when PC_CAUSE_EN is defined.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        irq,
    input  logic        exc,
    output logic [31:0] pc,
    output logic        kernel,
    output logic        nullify,
    output logic        xp_we,
    output logic [31:0] xp_data,
`ifdef PC_CAUSE_EN
    output logic [1:0]  cause,
    output logic [31:0] epc_reg,
`endif
    output logic        double_fault
);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        irq_pend_q, irq_pend_d;
    logic        df_q, df_d;
    logic        trap;
    logic [1:0]  trap_code;

    assign pc           = pc_q;
    assign kernel       = pc_q[31];
    assign double_fault = df_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        df_d       = df_q;
        irq_pend_d = irq_pend_q | irq;
        nullify    = 1'b0;
        xp_we      = 1'b0;
        xp_data    = pc_q + 32'd4;
        trap       = 1'b0;
        trap_code  = 2'b00;

        // A halted sequencer never lets an instruction commit, even while held.
        if (state_q == HALT) begin
            nullify = 1'b1;
        end else if (!hold) begin
            if (exc && !kernel) begin
                pc_d      = EXC_VEC;
                xp_we     = 1'b1;
                nullify   = 1'b1;
                trap      = 1'b1;
                trap_code = 2'b10;
            end else if (exc) begin
                state_d   = HALT;
                df_d      = 1'b1;
                nullify   = 1'b1;
                trap      = 1'b1;
                trap_code = 2'b11;
            end else if ((irq_pend_q || irq) && !kernel) begin
                pc_d       = IRQ_VEC;
                xp_we      = 1'b1;
                xp_data    = pc_q;
                nullify    = 1'b1;
                irq_pend_d = 1'b0;
                trap       = 1'b1;
                trap_code  = 2'b01;
            end else if (jr) begin
                pc_d = kernel ? jr_target : {1'b0, jr_target[30:0]};
            end else if (jump) begin
                pc_d = jump_target;
            end else if (branch_taken) begin
                pc_d = branch_target;
            end else begin
                pc_d = {pc_q[31], pc_q[30:0] + 31'd4};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_VEC;
            irq_pend_q <= 1'b0;
            df_q       <= 1'b0;
        end else begin
            irq_pend_q <= irq_pend_d;
            if (!hold) begin
                state_q <= state_d;
                pc_q    <= pc_d;
                df_q    <= df_d;
            end
        end
    end

`ifdef PC_CAUSE_EN
    logic [1:0]  cause_q;
    logic [31:0] epc_q;

    assign cause   = cause_q;
    assign epc_reg = epc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cause_q <= '0;
            epc_q   <= '0;
        end else if (trap) begin
            cause_q <= trap_code;
            epc_q   <= xp_data;
        end
    end
`else
    logic unused_trap;
    assign unused_trap = trap ^ (^trap_code);
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed steps push expectations into a scoreboard queue.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hold = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = '0;
    logic        irq = 1'b0;
    logic        exc = 1'b0;
    logic [31:0] pc;
    logic        kernel;
    logic        nullify;
    logic        xp_we;
    logic [31:0] xp_data;
    logic        double_fault;
`ifdef PC_CAUSE_EN
    logic [1:0]  cause;
    logic [31:0] epc_reg;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic        nul;
        logic        we;
        logic [31:0] xd;
        logic [31:0] npc;
        logic        df;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_VEC(32'h8000_0000),
        .IRQ_VEC  (32'h8000_0004),
        .EXC_VEC  (32'h8000_0008)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hold         (hold),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .jr           (jr),
        .jr_target    (jr_target),
        .irq          (irq),
        .exc          (exc),
        .pc           (pc),
        .kernel       (kernel),
        .nullify      (nullify),
        .xp_we        (xp_we),
        .xp_data      (xp_data),
`ifdef PC_CAUSE_EN
        .cause        (cause),
        .epc_reg      (epc_reg),
`endif
        .double_fault (double_fault)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then retire it at the edge.
    task automatic step(input string tag,
                        input logic h, input logic br, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt,
                        input logic r, input logic [31:0] rt,
                        input logic iq, input logic e,
                        input logic en, input logic ewe, input logic [31:0] exd,
                        input logic [31:0] enpc, input logic edf);
        exp_t x;
        hold = h; branch_taken = br; branch_target = bt;
        jump = j; jump_target = jt; jr = r; jr_target = rt;
        irq = iq; exc = e;
        x.tag = tag; x.nul = en; x.we = ewe; x.xd = exd; x.npc = enpc; x.df = edf;
        exp_q.push_back(x);
        @(negedge clk);
        x = exp_q[0];
        check_val({x.tag, ".nullify"}, {31'b0, nullify}, {31'b0, x.nul});
        check_val({x.tag, ".xp_we"}, {31'b0, xp_we}, {31'b0, x.we});
        if (x.we) check_val({x.tag, ".xp_data"}, xp_data, x.xd);
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        check_val({x.tag, ".pc"}, pc, x.npc);
        check_val({x.tag, ".kernel"}, {31'b0, kernel}, {31'b0, x.npc[31]});
        check_val({x.tag, ".double_fault"}, {31'b0, double_fault}, {31'b0, x.df});
    endtask

    task automatic idle(input string tag, input logic iq, input logic en, input logic ewe,
                        input logic [31:0] exd, input logic [31:0] enpc, input logic edf);
        step(tag, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, iq, 1'b0, en, ewe, exd, enpc, edf);
    endtask

    task automatic do_jr(input string tag, input logic [31:0] rt, input logic iq,
                         input logic [31:0] enpc);
        step(tag, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, rt, iq, 1'b0, 1'b0, 1'b0, '0, enpc, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #16;
        check_val("rst.pc", pc, 32'h8000_0000);
        check_val("rst.kernel", {31'b0, kernel}, 32'd1);
        check_val("rst.nullify", {31'b0, nullify}, 32'd0);
        check_val("rst.xp_we", {31'b0, xp_we}, 32'd0);
        check_val("rst.df", {31'b0, double_fault}, 32'd0);
        reset = 1'b1;

        idle("seq0", 1'b0, 1'b0, 1'b0, '0, 32'h8000_0004, 1'b0);
        idle("seq1", 1'b0, 1'b0, 1'b0, '0, 32'h8000_0008, 1'b0);
        idle("seq2", 1'b0, 1'b0, 1'b0, '0, 32'h8000_000C, 1'b0);

        do_jr("to_user10", 32'h0000_0010, 1'b0, 32'h0000_0010);
        step("irq_vs_jump", 1'b0, 1'b0, '0, 1'b1, 32'h0000_0200, 1'b0, '0, 1'b1, 1'b0,
             1'b1, 1'b1, 32'h0000_0010, 32'h8000_0004, 1'b0);
        do_jr("ret_user100", 32'h0000_0100, 1'b0, 32'h0000_0100);
        idle("pend_clear", 1'b0, 1'b0, 1'b0, '0, 32'h0000_0104, 1'b0);

        do_jr("user_jr_mask", 32'h8000_0100, 1'b0, 32'h0000_0100);

        do_jr("to_user20", 32'h0000_0020, 1'b0, 32'h0000_0020);
        step("user_exc", 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1,
             1'b1, 1'b1, 32'h0000_0024, 32'h8000_0008, 1'b0);

        do_jr("k_jr130", 32'h8000_0130, 1'b0, 32'h8000_0130);
        idle("k_irq_mask", 1'b1, 1'b0, 1'b0, '0, 32'h8000_0134, 1'b0);
        do_jr("k_jr_user40", 32'h0000_0040, 1'b1, 32'h0000_0040);
        idle("pend_take", 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h8000_0004, 1'b0);

        do_jr("to_7ffffffc", 32'h7FFF_FFFC, 1'b0, 32'h7FFF_FFFC);
        idle("wrap", 1'b0, 1'b0, 1'b0, '0, 32'h0000_0000, 1'b0);
        idle("after_wrap", 1'b0, 1'b0, 1'b0, '0, 32'h0000_0004, 1'b0);

        step("jump_vs_br", 1'b0, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0300, 1'b0, '0, 1'b0, 1'b0,
             1'b0, 1'b0, '0, 32'h0000_0300, 1'b0);
        step("branch", 1'b0, 1'b1, 32'h0000_0400, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0,
             1'b0, 1'b0, '0, 32'h0000_0400, 1'b0);
        step("jr_vs_jump", 1'b0, 1'b0, '0, 1'b1, 32'h0000_0700, 1'b1, 32'h0000_0500, 1'b0, 1'b0,
             1'b0, 1'b0, '0, 32'h0000_0500, 1'b0);

        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b1, 1'b1, 32'h0000_0600, 1'b0, '0, 1'b0, '0, (i == 0), 1'b0,
                 1'b0, 1'b0, '0, 32'h0000_0500, 1'b0);
        end
        step("irq_after_hold", 1'b0, 1'b1, 32'h0000_0600, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0,
             1'b1, 1'b1, 32'h0000_0500, 32'h8000_0004, 1'b0);

        do_jr("to_user20b", 32'h0000_0020, 1'b0, 32'h0000_0020);
        step("exc_irq_prio", 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1,
             1'b1, 1'b1, 32'h0000_0024, 32'h8000_0008, 1'b0);
        step("dbl_fault", 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1,
             1'b1, 1'b0, '0, 32'h8000_0008, 1'b1);
        idle("halt_idle", 1'b0, 1'b1, 1'b0, '0, 32'h8000_0008, 1'b1);
        step("halt_jr", 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h0000_0010, 1'b1, 1'b0,
             1'b1, 1'b0, '0, 32'h8000_0008, 1'b1);

        reset = 1'b0;
        jr = 1'b0; irq = 1'b0;
        #1;
        check_val("rst2.pc", pc, 32'h8000_0000);
        check_val("rst2.df", {31'b0, double_fault}, 32'd0);
        check_val("rst2.nullify", {31'b0, nullify}, 32'd0);
        reset = 1'b1;
        idle("post_rst", 1'b0, 1'b0, 1'b0, '0, 32'h8000_0004, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
